imem_fetch_ctrl: RTL and testbench

Instruction-fetch controller for the 16-word instruction memory. After reset it runs a load phase that streams a program into the memory's write port. It then sequences the program counter that drives the memory read address and registers each returned word into a valid/ready fetch stage for the decoder. Taken branches from execute redirect the PC and squash the in-flight fetch.

---
 rtl/imem_fetch_ctrl.sv | 95 +++++++++
 tb/tb_imem_fetch_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller: streams a program into instruction memory after reset,
// then sequences the PC and registers fetched words into a valid/ready stage with branch redirect.
module imem_fetch_ctrl #(
  parameter int          ADDR_W   = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load_valid,
  input  logic [31:0]       i_load_data,
  input  logic              i_load_done,
  output logic              o_load_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_waddr,
  output logic [31:0]       o_mem_wdata,
  output logic [31:0]       o_pc,
  input  logic [31:0]       i_mem_rdata,
  output logic [31:0]       o_instr_out,
  output logic              o_instr_valid,
  input  logic              i_instr_ready,
  input  logic              i_br_taken,
  input  logic [31:0]       i_br_target,
  output logic              o_running
);

  localparam logic [0:0]        ST_LOAD  = 1'b0;
  localparam logic [0:0]        ST_RUN   = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_load_ptr;
  logic [31:0]       r_pc;
  logic [31:0]       r_instr_out;
  logic              r_instr_valid;

  logic w_in_load;
  logic w_accept;
  logic w_load_end;
  logic w_adv;

  assign w_in_load  = (r_state == ST_LOAD);
  assign w_accept   = w_in_load && i_load_valid;
  // Memory full ends the load so word 0 is never overwritten by a wrapped pointer.
  assign w_load_end = w_in_load && (i_load_done || (w_accept && (r_load_ptr == LAST_PTR)));
  assign w_adv      = !r_instr_valid || i_instr_ready;

  assign o_load_ready  = w_in_load;
  assign o_mem_we      = w_accept;
  assign o_mem_waddr   = r_load_ptr;
  assign o_mem_wdata   = i_load_data;
  assign o_pc          = r_pc;
  assign o_instr_out   = r_instr_out;
  assign o_instr_valid = r_instr_valid;
  assign o_running     = (r_state == ST_RUN);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_LOAD;
      r_load_ptr    <= {ADDR_W{1'b0}};
      r_pc          <= RESET_PC;
      r_instr_out   <= 32'h0;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_accept) begin
            r_load_ptr <= r_load_ptr + PTR_ONE;
          end
          if (w_load_end) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_instr_valid <= 1'b0;
          end
        end
        ST_RUN: begin
          // A redirect squashes both the held word and the word at the old pc.
          if (i_br_taken) begin
            r_pc          <= i_br_target;
            r_instr_valid <= 1'b0;
          end else if (w_adv) begin
            r_instr_out   <= i_mem_rdata;
            r_instr_valid <= 1'b1;
            r_pc          <= r_pc + 32'd1;
          end
        end
        default: begin
          r_state       <= ST_LOAD;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: table-driven load vectors, hand-written fetch
// sequences, and a scoreboard of expected {instruction, pc} pairs checked on each transfer.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_done;
  logic        load_ready;
  logic        mem_we;
  logic [3:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [31:0] pc;
  logic [31:0] mem_rdata;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        br_taken;
  logic [31:0] br_target;
  logic        running;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(.ADDR_W(4), .RESET_PC(32'h0)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_load_valid(load_valid), .i_load_data(load_data), .i_load_done(load_done),
    .o_load_ready(load_ready), .o_mem_we(mem_we), .o_mem_waddr(mem_waddr),
    .o_mem_wdata(mem_wdata), .o_pc(pc), .i_mem_rdata(mem_rdata),
    .o_instr_out(instr_out), .o_instr_valid(instr_valid), .i_instr_ready(instr_ready),
    .i_br_taken(br_taken), .i_br_target(br_target), .o_running(running)
  );

  logic [31:0] mem [16];
  always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;
  assign mem_rdata = mem[pc[3:0]];

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;
  exp_t sb_q[$];
  exp_t e;

  typedef struct {
    logic        lv;
    logic [31:0] ld;
    logic        done;
    logic        exp_we;
    logic [3:0]  exp_waddr;
    logic        chk_waddr;
    logic        exp_ready;
    logic        exp_run;
  } vec_t;
  vec_t vecs[5];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] w(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  function automatic exp_t mk(input logic [31:0] d, input logic [31:0] p);
    exp_t r;
    r.data = d;
    r.pc   = p;
    return r;
  endfunction

  // A branch cycle is not a transfer: the held word is squashed.
  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready && !br_taken) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_xfer: got %h, expected no transfer", instr_out);
      end else begin
        e = sb_q.pop_front();
        chk("xfer_data", instr_out, e.data);
        chk("xfer_pc", pc, e.pc);
      end
    end
  end

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_data = 32'h0; load_done = 1'b0;
    instr_ready = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    vecs[0] = '{1'b0, 32'h0,         1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 32'hE0810312,  1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 32'hE2800001,  1'b0, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 32'hEAFFFFFD,  1'b1, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 32'hDEADBEEF,  1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr_out, 32'h0);

    // Load then run
    sb_q.push_back(mk(32'hE0810312, 32'd1));
    sb_q.push_back(mk(32'hE2800001, 32'd2));
    sb_q.push_back(mk(32'hEAFFFFFD, 32'd3));
    for (int i = 0; i < 5; i++) begin
      load_valid = vecs[i].lv; load_data = vecs[i].ld; load_done = vecs[i].done;
      if (i == 4) instr_ready = 1'b1;
      @(negedge clk);
      chk("vec_we", 32'(mem_we), 32'(vecs[i].exp_we));
      if (vecs[i].chk_waddr) chk("vec_waddr", 32'(mem_waddr), 32'(vecs[i].exp_waddr));
      chk("vec_load_ready", 32'(load_ready), 32'(vecs[i].exp_ready));
      chk("vec_running", 32'(running), 32'(vecs[i].exp_run));
      tick();
    end
    load_valid = 1'b0; load_done = 1'b0;
    repeat (3) tick();
    instr_ready = 1'b0;
    chk("mem0_loaded", mem[0], 32'hE0810312);
    chk("mem2_loaded", mem[2], 32'hEAFFFFFD);

    // Reset mid-run, then full 16-word load
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_run_running", 32'(running), 32'h0);
    chk("rst_run_ready", 32'(load_ready), 32'h1);
    chk("rst_run_valid", 32'(instr_valid), 32'h0);
    for (int i = 0; i < 16; i++) begin
      load_valid = 1'b1; load_data = w(i);
      @(negedge clk);
      chk("full_waddr", 32'(mem_waddr), 32'(i));
      chk("full_running", 32'(running), 32'h0);
      tick();
    end
    load_data = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_load_ready", 32'(load_ready), 32'h0);
      chk("full_we", 32'(mem_we), 32'h0);
      chk("full_running", 32'(running), 32'h1);
      tick();
    end
    load_valid = 1'b0;
    chk("full_mem0", mem[0], w(0));
    chk("full_mem15", mem[15], w(15));

    // Backpressure: first word held while instr_ready is low
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_pc", pc, 32'd1);
      chk("stall_instr", instr_out, w(0));
      chk("stall_valid", 32'(instr_valid), 32'h1);
      tick();
    end
    for (int i = 0; i < 4; i++) sb_q.push_back(mk(w(i), 32'(i + 1)));
    instr_ready = 1'b1;
    repeat (4) tick();
    instr_ready = 1'b0;
    chk("pre_br_pc", pc, 32'd5);

    // Branch at pc=5 to 2 while flowing: one bubble
    sb_q.push_back(mk(w(2), 32'd3));
    sb_q.push_back(mk(w(3), 32'd4));
    br_taken = 1'b1; br_target = 32'd2; instr_ready = 1'b1;
    tick();
    br_taken = 1'b0;
    @(negedge clk);
    chk("br_bubble_valid", 32'(instr_valid), 32'h0);
    chk("br_bubble_pc", pc, 32'd2);
    tick();
    repeat (2) tick();
    instr_ready = 1'b0;

    // Branch during a stall drops the held word
    tick();
    chk("held_instr", instr_out, w(4));
    br_taken = 1'b1; br_target = 32'd9;
    tick();
    br_taken = 1'b0;
    @(negedge clk);
    chk("stall_br_bubble", 32'(instr_valid), 32'h0);
    tick();
    chk("stall_br_instr", instr_out, w(9));
    chk("stall_br_pc", pc, 32'd10);
    sb_q.push_back(mk(w(9), 32'd10));
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;

    // Memory index wrap, then full 32-bit pc wrap
    sb_q.push_back(mk(w(15), 32'h10));
    sb_q.push_back(mk(w(0), 32'h11));
    br_taken = 1'b1; br_target = 32'h0000_000F;
    tick();
    br_taken = 1'b0; instr_ready = 1'b1;
    repeat (3) tick();
    instr_ready = 1'b0;
    sb_q.push_back(mk(w(15), 32'h0));
    sb_q.push_back(mk(w(0), 32'h1));
    br_taken = 1'b1; br_target = 32'hFFFF_FFFF;
    tick();
    br_taken = 1'b0; instr_ready = 1'b1;
    repeat (3) tick();
    instr_ready = 1'b0;

    // Mid-run reset, reload with load_done alone, contents intact
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_running", 32'(running), 32'h0);
    chk("mrst_valid", 32'(instr_valid), 32'h0);
    chk("mrst_pc", pc, 32'h0);
    chk("mrst_load_ready", 32'(load_ready), 32'h1);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    chk("reload_running", 32'(running), 32'h1);
    sb_q.push_back(mk(w(0), 32'd1));
    sb_q.push_back(mk(w(1), 32'd2));
    instr_ready = 1'b1;
    repeat (3) tick();
    instr_ready = 1'b0;
    chk("reload_mem0", mem[0], w(0));
    tick();
    chk("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
